// File: rtl/alu_pkg.sv
// Shared encodings for the 4-bit ALU and its
// multi-precision sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU slice: AND/OR/XOR/ADD
// with carry in/out for the ADD path only.
module alu
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] select,
  input  logic       carry_in,
  output logic [3:0] out,
  output logic       carry_out
);

  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b}
             + {4'b0, carry_in};

  // select one slice function; carry only for ADD
  always_comb begin
    out       = 4'h0;
    carry_out = 1'b0;
    unique case (1'b1)
      select == OP_AND: out = a & b;
      select == OP_OR:  out = a | b;
      select == OP_XOR: out = a ^ b;
      default: begin
        out       = sum[3:0];
        carry_out = sum[4];
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_top.sv
// Integration wrapper: sequencer plus the
// shared 4-bit ALU it drives.
module alu_seq_top
  import alu_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [1:0]   req_op,
  input  logic         req_carry_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         busy
);

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_select;
  logic       alu_carry_in;
  logic [3:0] alu_out;
  logic       alu_carry_out;

  alu_seq_ctrl #(
    .NIBBLES(NIBBLES)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_carry_in (req_carry_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .busy         (busy),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out),
    .alu_carry_out(alu_carry_out)
  );

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .select   (alu_select),
    .carry_in (alu_carry_in),
    .out      (alu_out),
    .carry_out(alu_carry_out)
  );

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-precision sequencer: walks a wide op
// through the external 4-bit ALU, LSB nibble first.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [1:0]   req_op,
  input  logic         req_carry_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         busy,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [1:0]   alu_select,
  output logic         alu_carry_in,
  input  logic [3:0]   alu_out,
  input  logic         alu_carry_out
);

  localparam int IW =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NIBBLES - 1);

  state_e        state;
  state_e        state_nx;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  res_reg;
  op_e           op_reg;
  logic          carry_reg;
  logic          accept;
  logic          last;
  logic          is_add;

  assign accept = req_valid & req_ready;
  assign last   = (idx == LAST);
  assign is_add = (op_reg == OP_ADD);

  assign busy       = (state != IDLE);
  assign rsp_result = res_reg;
  assign rsp_carry  = carry_reg;
  assign rsp_zero   = (res_reg == '0);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state, handshakes and ALU slice drive
  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_a        = 4'h0;
    alu_b        = 4'h0;
    alu_select   = 2'b00;
    alu_carry_in = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset)
          state_nx = RUN;
      end
      RUN: begin
        alu_a        = a_reg[4*idx +: 4];
        alu_b        = b_reg[4*idx +: 4];
        alu_select   = op_reg;
        alu_carry_in = is_add & carry_reg;
        if (last) state_nx = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture and per-slice result/carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      op_reg    <= OP_AND;
      carry_reg <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= req_a;
      b_reg     <= req_b;
      op_reg    <= op_e'(req_op);
      carry_reg <= (req_op == OP_ADD)
                 & req_carry_in;
    end else if (state == RUN) begin
      res_reg[4*idx +: 4] <= alu_out;
      carry_reg <= is_add & alu_carry_out;
      idx       <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl driving the
// 4-bit ALU; expected values computed by hand.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_op;
  logic         req_carry_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         busy;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [1:0]   alu_select;
  logic         alu_carry_in;
  logic [3:0]   alu_out;
  logic         alu_carry_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [16:0] q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(.NIBBLES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_carry_in (req_carry_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .busy         (busy),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out),
    .alu_carry_out(alu_carry_out)
  );

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .select   (alu_select),
    .carry_in (alu_carry_in),
    .out      (alu_out),
    .carry_out(alu_carry_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [1:0]  op,
                       input logic        cin);
    req_a        = a;
    req_b        = b;
    req_op       = op;
    req_carry_in = cin;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  task automatic run4(input string tag,
                      output logic [3:0] cins);
    cins = '0;
    for (int k = 0; k < N; k++) begin
      cins[k] = alu_carry_in;
      chk({tag, "_early"}, rsp_valid, 0);
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, rsp_valid, 1);
  endtask

  task automatic pop(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 0);
    chk({tag, "_rdy"}, req_ready, 1);
  endtask

  task automatic op_chk(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [1:0]  op,
                        input logic        cin,
                        input logic [15:0] er,
                        input logic        ec,
                        input logic        ez,
                        input logic [3:0]  ecin);
    logic [3:0] cins;
    issue(a, b, op, cin);
    run4(tag, cins);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_c"}, rsp_carry, ec);
    chk({tag, "_z"}, rsp_zero, ez);
    chk({tag, "_cin"}, cins, ecin);
    pop(tag);
  endtask

  initial begin
    logic [3:0] cins;
    logic       seen;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    req_op       = 2'b00;
    req_carry_in = 1'b0;
    rsp_ready    = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_c", rsp_carry, 0);
    chk("rst_z", rsp_zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b,
        alu_select, alu_carry_in}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_rdy", req_ready, 1);

    op_chk("add_ovf", 16'hFFFF, 16'h0001,
           OP_ADD, 1'b0, 16'h0000, 1, 1, 4'b1110);
    op_chk("add_cin", 16'h1234, 16'h0FCB,
           OP_ADD, 1'b1, 16'h2200, 0, 0, 4'b1111);
    op_chk("and", 16'hF0A5, 16'h3C3C,
           OP_AND, 1'b1, 16'h3024, 0, 0, 4'b0000);
    op_chk("or", 16'hF0A5, 16'h3C3C,
           OP_OR, 1'b1, 16'hFCBD, 0, 0, 4'b0000);
    op_chk("xor", 16'hF0A5, 16'h3C3C,
           OP_XOR, 1'b1, 16'hCC99, 0, 0, 4'b0000);

    issue(16'h0001, 16'h0002, OP_ADD, 1'b0);
    run4("bp", cins);
    req_a        = 16'hAAAA;
    req_b        = 16'h5555;
    req_op       = OP_XOR;
    req_carry_in = 1'b0;
    req_valid    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_res", rsp_result, 16'h0003);
      chk("bp_rdy", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_pop", rsp_valid, 0);
    chk("bp_idle_rdy", req_ready, 1);
    chk("bp_no_bypass", busy, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp2_acc", busy, 1);
    run4("bp2", cins);
    chk("bp2_res", rsp_result, 16'hFFFF);
    chk("bp2_c", rsp_carry, 0);
    pop("bp2");

    issue(16'h1111, 16'h2222, OP_ADD, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_res", rsp_result, 0);
    chk("mid_z", rsp_zero, 1);
    chk("mid_c", rsp_carry, 0);
    chk("mid_alu", {alu_a, alu_b,
        alu_select, alu_carry_in}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    chk("mid_nopulse", seen, 0);
    op_chk("post_rst", 16'h0001, 16'h0001,
           OP_ADD, 1'b0, 16'h0002, 0, 0, 4'b0000);

    fork
      begin : requester
        int          last_acc;
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [16:0] e;
        last_acc = -1;
        for (int i = 0; i < 8; i++) begin
          a   = 16'($urandom);
          b   = 16'($urandom);
          op  = 2'($urandom_range(0, 3));
          cin = 1'($urandom_range(0, 1));
          case (op)
            2'b00:   e = {1'b0, a & b};
            2'b01:   e = {1'b0, a | b};
            2'b10:   e = {1'b0, a ^ b};
            default: e = {1'b0, a} + {1'b0, b}
                       + {16'b0, cin};
          endcase
          req_a        = a;
          req_b        = b;
          req_op       = op;
          req_carry_in = cin;
          req_valid    = 1'b1;
          n = 0;
          while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
          end
          chk("s_acc_to", n < 200, 1);
          @(posedge clk); #1;
          q.push_back(e);
          if (last_acc >= 0)
            chk("s_interval",
                (cyc - last_acc) >= 6, 1);
          last_acc  = cyc;
          req_valid = 1'b0;
        end
      end
      begin : responder
        int          got;
        int          n;
        logic [16:0] e;
        got = 0;
        n   = 0;
        while (got < 8 && n < 3000) begin
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            e = (q.size() > 0) ? q.pop_front()
                               : 17'h1FFFF;
            chk("s_res", rsp_result, e[15:0]);
            chk("s_c", rsp_carry, e[16]);
            chk("s_z", rsp_zero, e[15:0] == 0);
            got++;
          end
          @(posedge clk); #1;
          n++;
        end
        rsp_ready = 1'b0;
        chk("s_count", got, 8);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-precision sequencer for the 4-bit ALU. It accepts one wide operation (NIBBLES*4 bits) over a valid/ready request channel.
- It drives the external combinational 4-bit ALU one nibble per clock, LSB nibble first, and chains the ALU carry between nibbles for ADD.
- It assembles the wide result and returns it on a valid/ready response channel.
- It sits between the datapath issue logic and the shared ALU instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (W = 4*NIBBLES); legal range >= 1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_a  in  W  operand A
- req_b  in  W  operand B
- req_op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 ADD (same as ALU alu_select)
- req_carry_in  in  1  initial carry, used for ADD only
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  W  wide result
- rsp_carry  out  1  final carry-out (ADD), else 0
- rsp_zero  out  1  rsp_result == 0
- busy  out  1  state != IDLE
- alu_a  out  4  ALU operand A slice
- alu_b  out  4  ALU operand B slice
- alu_select  out  2  ALU operation select
- alu_carry_in  out  1  ALU carry input
- alu_out  in  4  ALU result slice
- alu_carry_out  in  1  ALU carry output

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high.
- Reset values:
  - state IDLE, slice index 0.
  - a/b/op/carry/result registers 0.
  - rsp_valid 0, rsp_result 0, rsp_carry 0, rsp_zero 1.
  - req_ready 1 once reset deasserts; busy 0.
  - alu_a/alu_b/alu_select/alu_carry_in 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1; ALU outputs held at 0.
  - On req_valid & req_ready at the clock edge: capture req_a, req_b, req_op, and carry (req_carry_in if op==ADD, else 0). Set index=0 and go to RUN.
- RUN:
  - req_ready=0.
  - Combinational drive: alu_a = a_reg[4*idx+:4], alu_b = b_reg[4*idx+:4], alu_select = op_reg, alu_carry_in = carry_reg when op==ADD, else 0.
  - Each edge: result_reg[4*idx+:4] <= alu_out; carry_reg <= alu_carry_out if ADD, else 0; idx <= idx+1.
  - On the edge where idx == NIBBLES-1: go to DONE (idx wraps to 0).
- DONE:
  - rsp_valid=1; rsp_result, rsp_carry and rsp_zero are stable while rsp_valid is high. ALU outputs return to 0.
  - On rsp_ready: go to IDLE and drop rsp_valid.
  - Backpressure may hold DONE indefinitely.
- Latency: rsp_valid rises exactly NIBBLES clock edges after the accepting edge. Minimum issue interval is NIBBLES+2 cycles. There is no DONE->accept bypass in the same cycle.
- rsp_result/rsp_carry/rsp_zero hold the last result until the next result is written. Partial updates during RUN are allowed; consumers sample them only while rsp_valid is high.
- Requests asserted during RUN/DONE are not accepted (req_ready=0). The requester must hold them per valid/ready rules.
- rsp_ready asserted outside DONE has no effect.
- Reset mid-RUN or mid-DONE: the operation is abandoned, rsp_valid goes to 0 immediately, and no response is ever produced for it.
- NIBBLES=1: RUN lasts one cycle; behaviour is otherwise identical.
- Widths: idx counter is clog2(NIBBLES) bits, minimum 1 bit.

Decomposition:
- Shared package alu_pkg holds:
  - operation encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11, also used by the ALU mux select;
  - the controller state encoding IDLE/RUN/DONE.
- No sub-module inside the controller. The ALU stays external.
- A thin wrapper alu_seq_top instantiates ALU + alu_seq_ctrl for integration and test.

Test Plan (NIBBLES=4, via alu_seq_top):
- ADD 0xFFFF + 0x0001, cin=0:
  - result 0x0000, rsp_carry=1, rsp_zero=1;
  - rsp_valid rises 4 edges after accept;
  - alu_carry_in observed 0,1,1,1 over the RUN cycles.
- ADD 0x1234 + 0x0FCB, cin=1 -> result 0x2200, carry 0, zero 0.
- AND/OR/XOR on 0xF0A5 and 0x3C3C, cin=1:
  - results 0x3024 / 0xFCBD / 0xCC99;
  - rsp_carry=0; alu_carry_in stays 0 throughout.
- Backpressure:
  - rsp_ready held low 10 cycles in DONE: rsp_valid and rsp_result stay stable, req_ready stays 0.
  - A second req_valid held high is accepted only on the cycle after the rsp_ready handshake.
- Reset asserted asynchronously mid-RUN (after 2 slices) -> all outputs return to their reset values immediately, no rsp_valid pulse. A fresh ADD 0x0001+0x0001 afterwards returns 0x0002.
- Back-to-back stream of 8 random ops with random rsp_ready:
  - results match a W-bit reference model;
  - issue interval is never below 6 cycles.
